// File: rtl/life_pkg.sv
// Shared definitions for the generation sequencer: FSM state encoding and
// the supported range of the next-state compute latency.
package life_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        SWAP  = 2'd3
    } gen_state_e;

    localparam int CALC_LAT_MAX = 7;
    localparam int DRAIN_CNT_W  = $clog2(CALC_LAT_MAX + 1);

endpackage

// File: rtl/valid_delay.sv
// Fixed-depth shift register that delays a valid strobe by DEPTH cycles;
// cleared by reset so an aborted generation leaves no stray write strobes.
module valid_delay #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic valid_in,
    output logic valid_out
);

    logic [DEPTH-1:0] pipe_q;
    logic [DEPTH-1:0] pipe_d;

    always_comb begin
        pipe_d = (pipe_q << 1) | DEPTH'(valid_in);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pipe_q <= '0;
        end else begin
            pipe_q <= pipe_d;
        end
    end

    assign valid_out = pipe_q[DEPTH-1];

endmodule

// File: rtl/generation_sequencer.sv
// Sequences one cellular-automaton generation per trigger: toroidal row fetch,
// delayed next-state row writes, then a ping-pong buffer swap.
//
// state | meaning
// IDLE  | waiting for vsync (running) or step (paused)
// RUN   | issuing Y_SIZE+2 row fetches, one per cycle
// DRAIN | letting the last 1+CALC_LAT writes land
// SWAP  | toggle buffers, pulse gen_done, bump gen_count
module generation_sequencer
    import life_pkg::*;
#(
    parameter int Y_SIZE   = 720,
    parameter int Y_WIDTH  = 10,
    parameter int CALC_LAT = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               vsync,
    input  logic               pause,
    input  logic               step,
    output logic [Y_WIDTH-1:0] fetch_addr,
    output logic               fetch_valid,
    output logic [Y_WIDTH-1:0] write_addr,
    output logic               write_en,
    output logic               mode,
    output logic               busy,
    output logic               gen_done,
    output logic [15:0]        gen_count,
    output logic               overrun
);

    localparam int                     CNT_W      = Y_WIDTH + 1;
    localparam logic [CNT_W-1:0]       LAST_FETCH = CNT_W'(Y_SIZE + 1);
    localparam logic [Y_WIDTH-1:0]     LAST_ROW   = Y_WIDTH'(Y_SIZE - 1);
    localparam logic [DRAIN_CNT_W-1:0] DRAIN_LOAD = DRAIN_CNT_W'(CALC_LAT);

    gen_state_e             state_q, state_d;
    logic [Y_WIDTH-1:0]     fetch_addr_q, fetch_addr_d;
    logic                   fetch_valid_q, fetch_valid_d;
    logic [Y_WIDTH-1:0]     write_addr_q, write_addr_d;
    logic                   mode_q, mode_d;
    logic                   busy_q, busy_d;
    logic                   gen_done_q, gen_done_d;
    logic [15:0]            gen_count_q, gen_count_d;
    logic                   overrun_q, overrun_d;
    logic [CNT_W-1:0]       fetch_cnt_q, fetch_cnt_d;
    logic [DRAIN_CNT_W-1:0] drain_cnt_q, drain_cnt_d;
    logic                   start;
    logic                   wr_valid_in;
    logic                   write_en_w;

    // pause selects the trigger source, so vsync+step together start only once
    assign start = pause ? step : vsync;

    always_comb begin
        state_d       = state_q;
        fetch_addr_d  = fetch_addr_q;
        fetch_valid_d = fetch_valid_q;
        write_addr_d  = write_addr_q;
        mode_d        = mode_q;
        busy_d        = busy_q;
        gen_done_d    = 1'b0;
        gen_count_d   = gen_count_q;
        overrun_d     = overrun_q;
        fetch_cnt_d   = fetch_cnt_q;
        drain_cnt_d   = drain_cnt_q;

        // the first two fetches only prime the line buffer
        wr_valid_in = fetch_valid_q && (fetch_cnt_q >= CNT_W'(2));

        if (write_en_w) begin
            write_addr_d = (write_addr_q == LAST_ROW) ? '0 : write_addr_q + Y_WIDTH'(1);
        end

        if (busy_q && vsync) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d       = RUN;
                    fetch_valid_d = 1'b1;
                    fetch_addr_d  = LAST_ROW;
                    fetch_cnt_d   = '0;
                    write_addr_d  = '0;
                    busy_d        = 1'b1;
                end
            end
            RUN: begin
                if (fetch_cnt_q == LAST_FETCH) begin
                    state_d       = DRAIN;
                    fetch_valid_d = 1'b0;
                    fetch_addr_d  = '0;
                    drain_cnt_d   = DRAIN_LOAD;
                end else begin
                    fetch_cnt_d  = fetch_cnt_q + CNT_W'(1);
                    fetch_addr_d = (fetch_addr_q == LAST_ROW) ? '0 : fetch_addr_q + Y_WIDTH'(1);
                end
            end
            DRAIN: begin
                if (drain_cnt_q == '0) begin
                    state_d     = SWAP;
                    gen_done_d  = 1'b1;
                    mode_d      = ~mode_q;
                    gen_count_d = gen_count_q + 16'd1;
                end else begin
                    drain_cnt_d = drain_cnt_q - DRAIN_CNT_W'(1);
                end
            end
            SWAP: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            fetch_addr_q  <= '0;
            fetch_valid_q <= 1'b0;
            write_addr_q  <= '0;
            mode_q        <= 1'b0;
            busy_q        <= 1'b0;
            gen_done_q    <= 1'b0;
            gen_count_q   <= '0;
            overrun_q     <= 1'b0;
            fetch_cnt_q   <= '0;
            drain_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            fetch_addr_q  <= fetch_addr_d;
            fetch_valid_q <= fetch_valid_d;
            write_addr_q  <= write_addr_d;
            mode_q        <= mode_d;
            busy_q        <= busy_d;
            gen_done_q    <= gen_done_d;
            gen_count_q   <= gen_count_d;
            overrun_q     <= overrun_d;
            fetch_cnt_q   <= fetch_cnt_d;
            drain_cnt_q   <= drain_cnt_d;
        end
    end

    valid_delay #(
        .DEPTH(1 + CALC_LAT)
    ) u_valid_delay (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid_in  (wr_valid_in),
        .valid_out (write_en_w)
    );

    assign fetch_addr  = fetch_addr_q;
    assign fetch_valid = fetch_valid_q;
    assign write_addr  = write_addr_q;
    assign write_en    = write_en_w;
    assign mode        = mode_q;
    assign busy        = busy_q;
    assign gen_done    = gen_done_q;
    assign gen_count   = gen_count_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_generation_sequencer.sv
// Scoreboard bench for generation_sequencer (Y_SIZE=8, CALC_LAT=1): expected
// fetch/write rows and generation counts are queued when a trigger is driven.
module tb_generation_sequencer;

    localparam int Y_SIZE     = 8;
    localparam int Y_WIDTH    = 10;
    localparam int CALC_LAT   = 1;
    localparam int GEN_CYCLES = Y_SIZE + 2 + 1 + CALC_LAT + 1;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               vsync;
    logic               pause;
    logic               step;
    logic [Y_WIDTH-1:0] fetch_addr;
    logic               fetch_valid;
    logic [Y_WIDTH-1:0] write_addr;
    logic               write_en;
    logic               mode;
    logic               busy;
    logic               gen_done;
    logic [15:0]        gen_count;
    logic               overrun;

    always #5 clk = ~clk;

    generation_sequencer #(
        .Y_SIZE   (Y_SIZE),
        .Y_WIDTH  (Y_WIDTH),
        .CALC_LAT (CALC_LAT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .vsync       (vsync),
        .pause       (pause),
        .step        (step),
        .fetch_addr  (fetch_addr),
        .fetch_valid (fetch_valid),
        .write_addr  (write_addr),
        .write_en    (write_en),
        .mode        (mode),
        .busy        (busy),
        .gen_done    (gen_done),
        .gen_count   (gen_count),
        .overrun     (overrun)
    );

    int          errors = 0;
    int          checks = 0;
    int          exp_fetch[$];
    int          exp_write[$];
    logic [15:0] exp_count[$];
    logic [15:0] model_cnt = '0;
    logic [15:0] mon_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_gen();
        exp_fetch.push_back(Y_SIZE - 1);
        for (int r = 0; r < Y_SIZE; r++) exp_fetch.push_back(r);
        exp_fetch.push_back(0);
        for (int r = 0; r < Y_SIZE; r++) exp_write.push_back(r);
        model_cnt = model_cnt + 16'd1;
        exp_count.push_back(model_cnt);
    endtask

    task automatic flush_sb();
        exp_fetch.delete();
        exp_write.delete();
        exp_count.delete();
        model_cnt = '0;
    endtask

    task automatic pulse(input logic v, input logic s);
        vsync = v;
        step  = s;
        tick(1);
        vsync = 1'b0;
        step  = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int exp_cycles);
        int n;
        n = 0;
        while (!gen_done && n < 4 * GEN_CYCLES) begin
            tick(1);
            n++;
        end
        chk({tag, "_latency"}, 32'(n), 32'(exp_cycles));
        tick(1);
        chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
        chk({tag, "_count"}, 32'(gen_count), 32'(model_cnt));
        chk({tag, "_mode"}, 32'(mode), 32'(model_cnt[0]));
        chk({tag, "_fetch_left"}, 32'(exp_fetch.size()), 32'd0);
        chk({tag, "_write_left"}, 32'(exp_write.size()), 32'd0);
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (fetch_valid) begin
                if (exp_fetch.size() == 0) chk("fetch_unexpected", 32'(fetch_valid), 32'd0);
                else chk("fetch_addr", 32'(fetch_addr), 32'(exp_fetch.pop_front()));
            end
            if (write_en) begin
                if (exp_write.size() == 0) chk("write_unexpected", 32'(write_en), 32'd0);
                else chk("write_addr", 32'(write_addr), 32'(exp_write.pop_front()));
            end
            if (gen_done) begin
                if (exp_count.size() == 0) begin
                    chk("gen_done_unexpected", 32'(gen_done), 32'd0);
                end else begin
                    mon_cnt = exp_count.pop_front();
                    chk("gen_count_at_swap", 32'(gen_count), 32'(mon_cnt));
                    chk("mode_at_swap", 32'(mode), 32'(mon_cnt[0]));
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        vsync = 1'b0;
        pause = 1'b0;
        step  = 1'b0;
        tick(2);
        chk("rst_fetch_valid", 32'(fetch_valid), 32'd0);
        chk("rst_fetch_addr", 32'(fetch_addr), 32'd0);
        chk("rst_write_en", 32'(write_en), 32'd0);
        chk("rst_write_addr", 32'(write_addr), 32'd0);
        chk("rst_mode", 32'(mode), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_gen_done", 32'(gen_done), 32'd0);
        chk("rst_gen_count", 32'(gen_count), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        rst_n = 1'b1;
        tick(1);

        // abort: reset sampled at the end of the 4th RUN cycle
        push_gen();
        pulse(1'b1, 1'b0);
        tick(3);
        rst_n = 1'b0;
        tick(1);
        chk("abort_fetch_valid", 32'(fetch_valid), 32'd0);
        chk("abort_fetch_addr", 32'(fetch_addr), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_mode", 32'(mode), 32'd0);
        chk("abort_gen_count", 32'(gen_count), 32'd0);
        chk("abort_write_en", 32'(write_en), 32'd0);
        flush_sb();
        tick(2);
        rst_n = 1'b1;
        tick(GEN_CYCLES);
        chk("abort_after_busy", 32'(busy), 32'd0);
        chk("abort_after_mode", 32'(mode), 32'd0);

        // basic generation from vsync
        push_gen();
        pulse(1'b1, 1'b0);
        chk("run_busy", 32'(busy), 32'd1);
        wait_done("gen1", GEN_CYCLES - 1);

        // paused: vsync ignored; step while running is ignored
        pause = 1'b1;
        pulse(1'b1, 1'b0);
        tick(GEN_CYCLES);
        chk("pause_vsync_busy", 32'(busy), 32'd0);
        chk("pause_vsync_count", 32'(gen_count), 32'(model_cnt));
        chk("pause_vsync_overrun", 32'(overrun), 32'd0);
        pause = 1'b0;
        pulse(1'b0, 1'b1);
        tick(3);
        chk("step_unpaused_busy", 32'(busy), 32'd0);
        pause = 1'b1;
        push_gen();
        pulse(1'b0, 1'b1);
        tick(3);
        pulse(1'b0, 1'b1);
        wait_done("step_gen", GEN_CYCLES - 1 - 4);
        tick(GEN_CYCLES);
        chk("step_no_second", 32'(busy), 32'd0);

        // vsync and step in the same cycle start one generation
        push_gen();
        pulse(1'b1, 1'b1);
        wait_done("both_paused", GEN_CYCLES - 1);
        pause = 1'b0;
        push_gen();
        pulse(1'b1, 1'b1);
        wait_done("both_running", GEN_CYCLES - 1);
        tick(GEN_CYCLES);
        chk("both_no_second", 32'(gen_count), 32'(model_cnt));

        // overrun, and pause toggling mid-generation does not abort it
        push_gen();
        pulse(1'b1, 1'b0);
        tick(2);
        pulse(1'b1, 1'b0);
        pause = 1'b1;
        chk("overrun_set", 32'(overrun), 32'd1);
        wait_done("overrun_gen", GEN_CYCLES - 1 - 3);
        tick(GEN_CYCLES);
        chk("overrun_no_second", 32'(busy), 32'd0);
        pause = 1'b0;
        push_gen();
        pulse(1'b1, 1'b0);
        wait_done("overrun_next", GEN_CYCLES - 1);
        chk("overrun_sticky", 32'(overrun), 32'd1);
        rst_n = 1'b0;
        tick(2);
        flush_sb();
        chk("overrun_cleared", 32'(overrun), 32'd0);
        chk("reset2_mode", 32'(mode), 32'd0);
        rst_n = 1'b1;
        tick(1);

        // counter wrap via preload (even value keeps mode parity consistent)
        force dut.gen_count_q = 16'hFFFE;
        tick(1);
        release dut.gen_count_q;
        model_cnt = 16'hFFFE;
        tick(1);
        chk("preload", 32'(gen_count), 32'hFFFE);
        for (int g = 0; g < 3; g++) begin
            push_gen();
            pulse(1'b1, 1'b0);
            wait_done("wrap", GEN_CYCLES - 1);
        end
        chk("wrap_final_count", 32'(gen_count), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/generation_sequencer.md
GENERATION_SEQUENCER -- requirements
Module: generation_sequencer

Interface
REQ-001 SHALL have parameter Y_SIZE, default 720, number of grid rows.
REQ-002 SHALL have parameter Y_WIDTH, default 10, row address width.
REQ-003 SHALL have parameter CALC_LAT, default 1, next-state compute latency in cycles (0..7).
REQ-004 SHALL have port clk  input  1  single system clock, all logic rising-edge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port vsync  input  1  one-cycle frame-start pulse.
REQ-007 SHALL have port pause  input  1  level; 1 holds the grid frozen.
REQ-008 SHALL have port step  input  1  one-cycle pulse; requests one generation while paused.
REQ-009 SHALL have port fetch_addr  output  Y_WIDTH  line-buffer row read address.
REQ-010 SHALL have port fetch_valid  output  1  fetch_addr is issued this cycle.
REQ-011 SHALL have port write_addr  output  Y_WIDTH  next-state row write address.
REQ-012 SHALL have port write_en  output  1  next-state row write strobe.
REQ-013 SHALL have port mode  output  1  ping-pong buffer select; 1 = buffer A read / B write.
REQ-014 SHALL have port busy  output  1  generation in progress.
REQ-015 SHALL have port gen_done  output  1  one-cycle pulse at buffer swap.
REQ-016 SHALL have port gen_count  output  16  completed generations, wraps at 2^16.
REQ-017 SHALL have port overrun  output  1  sticky: vsync arrived while busy.

Function
REQ-018 SHALL implement states IDLE, RUN, DRAIN, SWAP.
REQ-019 IDLE->RUN SHALL occur on vsync with pause=0, or on step with pause=1; otherwise stay in IDLE.
REQ-020 RUN SHALL issue Y_SIZE+2 fetches, one per cycle, fetch_valid=1, in toroidal order Y_SIZE-1, 0, 1, ..., Y_SIZE-1, 0.
REQ-021 RUN->DRAIN SHALL occur after the last fetch (row 0, second time).
REQ-022 write_en SHALL equal fetch_valid delayed by 1+CALC_LAT cycles, forced to 0 for the first two fetches of each generation.
REQ-023 write_addr SHALL start at 0 each generation and increment after each write_en cycle, covering 0..Y_SIZE-1 exactly once.
REQ-024 DRAIN SHALL last 1+CALC_LAT cycles so that the final write (row Y_SIZE-1) completes; then go to SWAP.
REQ-025 SWAP SHALL last one cycle: toggle mode, pulse gen_done, increment gen_count; then go to IDLE.
REQ-026 mode SHALL change only in SWAP, never mid-generation.
REQ-027 busy SHALL be 1 in RUN, DRAIN and SWAP, and 0 in IDLE.
REQ-028 vsync or step while busy SHALL be ignored (not queued); vsync while busy SHALL set overrun.
REQ-029 pause changing while busy SHALL NOT abort the generation; it is sampled only in IDLE.
REQ-030 step while pause=0 SHALL be ignored.
REQ-031 vsync and step in the same IDLE cycle SHALL start exactly one generation.
REQ-032 fetch_addr wrap from Y_SIZE-1 to 0 SHALL use a compare against Y_SIZE-1, not a power-of-two rollover.
REQ-033 A generation SHALL take Y_SIZE+2 (RUN) + 1+CALC_LAT (DRAIN) + 1 (SWAP) cycles.

Reset
REQ-034 With rst_n=0 at a clock edge: state=IDLE, mode=0, fetch_addr=0, fetch_valid=0, write_addr=0, write_en=0, busy=0, gen_done=0, gen_count=0, overrun=0, and the delay line cleared.
REQ-035 Reset asserted mid-generation SHALL abort it with no further write_en and no mode toggle.

Structure
REQ-036 The state encoding and the CALC_LAT maximum SHALL be placed in shared package life_pkg.
REQ-037 The write_en delay line SHALL be a sub-module valid_delay, parameterised by depth 1+CALC_LAT.

Verification
REQ-038 Use Y_SIZE=8, CALC_LAT=1. Reset, then vsync with pause=0 -> fetch_addr sequence 7,0,1,2,3,4,5,6,7,0; write_addr 0..7; mode goes 0->1; gen_count=1; gen_done pulses after 13 cycles.
REQ-039 pause=1 with vsync -> no generation; step -> one generation, mode toggles once; a second step mid-run is ignored.
REQ-040 vsync during RUN -> overrun=1 stays set, no second generation; only rst_n clears overrun.
REQ-041 rst_n=0 at the 4th RUN cycle -> all outputs at reset values next cycle, mode=0, gen_count unchanged at 0.
REQ-042 Run 2^16+1 generations (forced counter preload allowed) -> gen_count wraps to 0 then 1; mode parity matches gen_count[0].
